// File: rtl/evm_codec_pkg.sv
// Shared types, constants and bit helpers for the EVM shift encoder/decoder pair.
// Block and key vectors use ascending [0:63] ranges, so bit 0 is the MSB.
package evm_codec_pkg;

  localparam int unsigned BLOCK_W   = 64;
  localparam int unsigned KEY_BYTES = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned ROUND_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    XOR,
    SHIFT,
    DONE
  } state_t;

  typedef logic [0:BLOCK_W-1] block_t;

  // Rotate right by one: the LSB (bit 63) wraps around into the MSB (bit 0).
  function automatic block_t rotr1(input block_t x);
    return {x[BLOCK_W-1], x[0:BLOCK_W-2]};
  endfunction

  function automatic block_t rotl1(input block_t x);
    return {x[1:BLOCK_W-1], x[0]};
  endfunction

  // Byte j is key[8j:8j+7]; key[8j] becomes bit 7 of the returned byte.
  function automatic logic [BYTE_W-1:0] key_byte(input block_t key,
                                                 input logic [ROUND_W-1:0] j);
    return key[{j, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/shift_decoding.sv
// Iterative 64-bit decoder: undoes the eight shift_encoding key-byte rounds in
// reverse order (XOR with the replicated byte, then rotate right one bit per clock).
module shift_decoding
  import evm_codec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic [0:BLOCK_W-1] data_in,
  input  logic [0:BLOCK_W-1] key,
  output logic [0:BLOCK_W-1] data_out,
  output logic               status
);

  state_t               st_q, st_d;
  block_t               blk_q, blk_d;
  block_t               key_q, key_d;
  logic [SHIFT_W-1:0]   cnt_q, cnt_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  block_t               out_d;
  logic                 status_d;

  logic [BYTE_W-1:0]    kb_c;
  logic [SHIFT_W-1:0]   s_c;
  logic                 round_end_c;

  assign kb_c = key_byte(key_q, round_q);
  assign s_c  = kb_c[SHIFT_W-1:0];

  // Next-state and datapath; set has the final word over whatever the FSM decided.
  always_comb begin
    st_d        = st_q;
    blk_d       = blk_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    round_d     = round_q;
    out_d       = data_out;
    status_d    = status;
    round_end_c = 1'b0;

    case (st_q)
      XOR: begin
        blk_d = blk_q ^ {KEY_BYTES{kb_c}};
        cnt_d = s_c;
        if (s_c == SHIFT_W'(0)) round_end_c = 1'b1;
        else                    st_d        = SHIFT;
      end
      SHIFT: begin
        blk_d = rotr1(blk_q);
        cnt_d = cnt_q - SHIFT_W'(1);
        if (cnt_q == SHIFT_W'(1)) round_end_c = 1'b1;
      end
      default: ;
    endcase

    // The final round's result goes straight to the output register.
    if (round_end_c) begin
      if (round_q == ROUND_W'(0)) begin
        st_d     = DONE;
        out_d    = blk_d;
        status_d = 1'b1;
      end else begin
        round_d = round_q - ROUND_W'(1);
        st_d    = XOR;
      end
    end

    if (set) begin
      blk_d    = data_in;
      key_d    = key;
      round_d  = ROUND_W'(KEY_BYTES - 1);
      cnt_d    = '0;
      status_d = 1'b0;
      out_d    = data_out;
      st_d     = XOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      blk_q    <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      round_q  <= '0;
      data_out <= '0;
      status   <= 1'b0;
    end else begin
      st_q     <= st_d;
      blk_q    <= blk_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      data_out <= out_d;
      status   <= status_d;
    end
  end

endmodule

// File: tb/tb_shift_decoding.sv
// Directed self-checking bench for shift_decoding: latency, plaintext, abort and reset.
module tb_shift_decoding;

  logic        clk;
  logic        rst;
  logic        set;
  logic [63:0] data_in;
  logic [63:0] key;
  logic [63:0] data_out;
  logic        status;

  int n_cmp = 0;
  int n_bad = 0;

  shift_decoding dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference decode with whole-amount rotates; byte j sits at bits [63-8j -: 8].
  function automatic logic [63:0] ref_dec(input logic [63:0] d, input logic [63:0] k);
    logic [7:0]  kb;
    logic [5:0]  s;
    logic [63:0] t;
    for (int j = 7; j >= 0; j--) begin
      kb = k[63-8*j -: 8];
      s  = kb[5:0];
      t  = d ^ {8{kb}};
      d  = (t >> s) | (t << (7'd64 - {1'b0, s}));
    end
    return d;
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] d, input logic [63:0] k);
    logic [7:0] kb;
    logic [5:0] s;
    for (int j = 0; j < 8; j++) begin
      kb = k[63-8*j -: 8];
      s  = kb[5:0];
      d  = ((d << s) | (d >> (7'd64 - {1'b0, s}))) ^ {8{kb}};
    end
    return d;
  endfunction

  // One-edge load; inputs are scrambled afterwards to prove they are only sampled at load.
  task automatic load(input logic [63:0] d, input logic [63:0] k);
    @(negedge clk);
    data_in = d;
    key     = k;
    set     = 1'b1;
    @(posedge clk);
    #1;
    check("status_clr_on_load", 64'(status), 64'd0);
    @(negedge clk);
    set     = 1'b0;
    data_in = ~d;
    key     = ~k;
  endtask

  // Counts edges after the load edge until status rises, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!status && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [63:0] d, input logic [63:0] k,
                          input int exp_lat, input logic [63:0] exp_out);
    int lat;
    load(d, k);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_out"}, data_out, exp_out);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [63:0] prev;
    logic [63:0] kx;
    rst     = 1'b1;
    set     = 1'b0;
    data_in = '0;
    key     = '0;
    kx      = 64'h0102030405060708;
    repeat (2) @(posedge clk);
    #1;
    check("reset_status", 64'(status), 64'd0);
    check("reset_data_out", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("zero_key",  64'h8967452301efcdab, 64'h0, 8, 64'h8967452301efcdab);
    check("status_holds", 64'(status), 64'd1);
    run_case("k7_one",    64'h0101010101010101, 64'h0000000000000001, 9, 64'h0);
    run_case("k0_one",    64'h0000000000000001, 64'h0100000000000000, 9, 64'h0080808080808080);
    run_case("k0_s0",     64'h0, 64'h4000000000000000, 8, 64'h4040404040404040);
    run_case("full_key",  64'h8967452301efcdab, kx, 44, ref_dec(64'h8967452301efcdab, kx));
    check("roundtrip", ref_enc(data_out, kx), 64'h8967452301efcdab);

    // Re-load mid-decode: old run discarded, data_out keeps the last completion.
    prev = data_out;
    load(64'h1122334455667788, kx);
    repeat (19) @(posedge clk);
    load(64'hdeadbeefcafef00d, kx);
    check("abort_keeps_out", data_out, prev);
    wait_done(lat);
    check("reload_lat", 64'(lat), 64'd44);
    check("reload_out", data_out, ref_dec(64'hdeadbeefcafef00d, kx));

    // Asynchronous reset mid-decode: outputs clear before any clock edge.
    load(64'h8967452301efcdab, kx);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_status", 64'(status), 64'd0);
    check("rst_async_out", data_out, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (status) seen++;
    end
    check("rst_no_completion", 64'(seen), 64'd0);
    check("rst_out_stays_zero", data_out, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
